// File: rtl/quad_decoder_pkg.sv
// quad_decoder_pkg: shared encoding for the quadrature decoder.
//   S0..S3         : decoder states as the filtered {A,B} pair
//   step_e         : per-cycle decode result (NONE, CW, CCW, ERR)
//   FILTER_DEFAULT : default glitch-filter depth in clock cycles
//   WINDOW_DEFAULT : default velocity window in clock cycles
//   classify()     : maps a {A,B} transition to its step_e result
package quad_decoder_pkg;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S3 = 2'b11;
    localparam logic [1:0] S2 = 2'b10;

    localparam int FILTER_DEFAULT = 4;
    localparam int WINDOW_DEFAULT = 120000;

    typedef enum logic [1:0] {NONE, CW, CCW, ERR} step_e;

    // Clockwise order is S0->S1->S3->S2->S0; a change of both bits is illegal.
    function automatic step_e classify(input logic [1:0] cur, input logic [1:0] nxt);
        logic [1:0] cw_next;
        cw_next = (cur == S0) ? S1 : (cur == S1) ? S3 : (cur == S3) ? S2 : S0;
        return (cur == nxt) ? NONE : (cur == ~nxt) ? ERR : (nxt == cw_next) ? CW : CCW;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// quad_filter: single-bit glitch filter; the output follows the input only
// after FILTER consecutive identical samples that differ from it.
//   CLK   : clock
//   reset : asynchronous active-high reset (output and counter to 0)
//   in    : synchronized input bit
//   out   : filtered bit
module quad_filter
    import quad_decoder_pkg::*;
#(
    parameter int FILTER = FILTER_DEFAULT
) (
    input  logic CLK,
    input  logic reset,
    input  logic in,
    output logic out
);

    logic [7:0] cnt;

    // The counter only runs while the input disagrees with the output, so a
    // return to the accepted value restarts the qualification.
    always_ff @(posedge CLK or posedge reset)
        if (reset) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (in == out) begin
            cnt <= '0;
        end else if (cnt == 8'(FILTER - 1)) begin
            cnt <= '0;
            out <= in;
        end else begin
            cnt <= cnt + 8'd1;
        end

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: filtered quadrature decoder with position and velocity.
//   CLK      : single clock
//   reset    : asynchronous active-high reset
//   enc_a/b  : raw asynchronous encoder phases
//   clear    : synchronous position clear (wins over a coincident step)
//   position : signed 8-bit wrapping step count
//   step_cw  : one-cycle pulse per clockwise step
//   step_ccw : one-cycle pulse per counter-clockwise step
//   err      : one-cycle pulse per illegal (double-bit) transition
//   velocity : signed steps in the last completed window, saturated
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int FILTER = FILTER_DEFAULT,
    parameter int WINDOW = WINDOW_DEFAULT
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       clear,
    output logic [7:0] position,
    output logic       step_cw,
    output logic       step_ccw,
    output logic       err,
    output logic [7:0] velocity
);

    logic [1:0]        sync_a, sync_b;
    logic              filt_a, filt_b;
    logic [1:0]        filt, state;
    logic              aligned, aligned_next;
    step_e             dir;
    logic signed [8:0] step9, acc, acc_next;
    logic signed [9:0] acc_sum;
    logic [23:0]       wcnt;

    always_ff @(posedge CLK or posedge reset)
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[0], enc_a};
            sync_b <= {sync_b[0], enc_b};
        end

    quad_filter #(.FILTER(FILTER)) u_filt_a (.CLK(CLK), .reset(reset), .in(sync_a[1]), .out(filt_a));
    quad_filter #(.FILTER(FILTER)) u_filt_b (.CLK(CLK), .reset(reset), .in(sync_b[1]), .out(filt_b));

    assign filt = {filt_a, filt_b};

    // Until the filters have caught up with the synchronized pins, the decoder
    // silently tracks the filtered pair so power-up alignment never counts.
    always_ff @(posedge CLK or posedge reset)
        if (reset) begin
            state   <= S0;
            aligned <= 1'b0;
        end else begin
            state   <= filt;
            aligned <= aligned_next;
        end

    always_comb begin
        aligned_next = aligned | ({sync_a[1], sync_b[1]} == filt);
        dir          = aligned ? classify(state, filt) : NONE;
        step9        = (dir == CW) ? 9'sd1 : (dir == CCW) ? -9'sd1 : 9'sd0;
        acc_sum      = {acc[8], acc} + {step9[8], step9};
        acc_next     = (acc_sum > 10'sd255) ? 9'sd255 : (acc_sum < -10'sd255) ? -9'sd255 : acc_sum[8:0];
    end

    always_ff @(posedge CLK or posedge reset)
        if (reset) begin
            step_cw  <= 1'b0;
            step_ccw <= 1'b0;
            err      <= 1'b0;
            position <= '0;
        end else begin
            step_cw  <= (dir == CW);
            step_ccw <= (dir == CCW);
            err      <= (dir == ERR);
            position <= clear ? 8'd0 : position + step9[7:0];
        end

    // A step landing on the window-end cycle belongs to the new window.
    always_ff @(posedge CLK or posedge reset)
        if (reset) begin
            wcnt     <= '0;
            acc      <= '0;
            velocity <= '0;
        end else if (wcnt == 24'(WINDOW - 1)) begin
            wcnt     <= '0;
            acc      <= step9;
            velocity <= (acc > 9'sd127) ? 8'd127 : (acc < -9'sd128) ? 8'h80 : acc[7:0];
        end else begin
            wcnt     <= wcnt + 24'd1;
            acc      <= acc_next;
        end

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: randomized and directed bench with a windowed reference model.
module tb_quad_decoder;

    localparam int FILTER = 4;
    localparam int WINDOW = 1000;

    logic       CLK, reset, enc_a, enc_b, clear;
    logic [7:0] position, velocity;
    logic       step_cw, step_ccw, err;

    quad_decoder #(.FILTER(FILTER), .WINDOW(WINDOW)) dut (
        .CLK(CLK), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .position(position), .step_cw(step_cw), .step_ccw(step_ccw), .err(err),
        .velocity(velocity)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    int errors = 0, checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Gray position along the clockwise cycle: S0=0, S1=1, S3=2, S2=3.
    function automatic int ord(input logic [1:0] s);
        return (s == 2'b00) ? 0 : (s == 2'b01) ? 1 : (s == 2'b11) ? 2 : 3;
    endfunction

    function automatic int clip(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    // Reference model: a phase is accepted once its synchronized value has
    // been seen FILTER times in a row; the decoder then reports the move one
    // cycle later, classified by distance travelled around the gray cycle.
    logic [1:0] rh [10];
    logic [1:0] m_filt, m_state;
    bit         m_armed, same;
    int         m_dir, m_pos, m_acc, m_vel, m_wc, step, cyc = 0;
    int         n_cw = 0, n_ccw = 0, n_err = 0;
    int         lat_from, lat = -1;
    bit         lat_on = 0;

    always @(posedge CLK) begin
        cyc++;
        if (reset) begin
            for (int i = 0; i < 10; i++) rh[i] = 2'b00;
            m_filt = 0; m_state = 0; m_armed = 0; m_dir = 0;
            m_pos = 0; m_acc = 0; m_vel = 0; m_wc = 0;
        end else begin
            for (int i = 9; i > 0; i--) rh[i] = rh[i-1];
            rh[0] = {enc_a, enc_b};
            m_dir   = m_armed ? (ord(m_filt) - ord(m_state) + 4) % 4 : 0;
            m_armed = m_armed || (rh[2] == m_filt);
            m_state = m_filt;
            for (int b = 0; b < 2; b++) begin
                same = 1;
                for (int i = 3; i <= FILTER + 1; i++) if (rh[i][b] != rh[2][b]) same = 0;
                if (same) m_filt[b] = rh[2][b];
            end
            step  = (m_dir == 1) ? 1 : (m_dir == 3) ? -1 : 0;
            m_pos = clear ? 0 : (m_pos + step) & 255;
            if (m_wc == WINDOW - 1) begin
                m_vel = clip(m_acc, -128, 127);
                m_acc = step;
                m_wc  = 0;
            end else begin
                m_acc = clip(m_acc + step, -255, 255);
                m_wc++;
            end
            #1;
            check("step_cw", step_cw, int'(m_dir == 1));
            check("step_ccw", step_ccw, int'(m_dir == 3));
            check("err", err, int'(m_dir == 2));
            check("position", position, m_pos);
            check("velocity", velocity, m_vel & 255);
            n_cw  += int'(step_cw);
            n_ccw += int'(step_ccw);
            n_err += int'(err);
            if (lat_on && step_cw) begin
                lat    = cyc - lat_from;
                lat_on = 0;
            end
        end
    end

    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int k = 0, n0, rel, r;

    task automatic put(input logic [1:0] ab, input int hold, input logic clr);
        @(negedge CLK);
        {enc_a, enc_b} = ab;
        clear = clr;
        repeat (hold) @(posedge CLK);
    endtask

    task automatic walk(input int d, input int hold);
        k = (k + d + 4) % 4;
        put(seq[k], hold, 1'b0);
    endtask

    task automatic settle();
        repeat (12) @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        reset = 1; enc_a = 0; enc_b = 0; clear = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        reset = 0;
        check("rst_position", position, 0);
        check("rst_velocity", velocity, 0);
        check("rst_pulses", {step_cw, step_ccw, err}, 0);
        repeat (5) @(posedge CLK);

        @(negedge CLK);
        lat_from = cyc; lat_on = 1; k = 1;
        {enc_a, enc_b} = seq[k];
        repeat (20) @(posedge CLK);
        walk(1, 20); walk(1, 20); walk(1, 20);
        settle();
        check("seq_cw_count", n_cw, 4);
        check("seq_position", position, 4);
        check("seq_latency", lat, 7);

        n0 = n_cw + n_ccw + n_err;
        put(2'b10, 3, 1'b0);
        put(2'b00, 20, 1'b0);
        settle();
        check("glitch_pulses", n_cw + n_ccw + n_err, n0);
        check("glitch_position", position, 4);

        put(2'b11, 20, 1'b0);
        k = 2;
        settle();
        check("jump_err", n_err, 1);
        check("jump_position", position, 4);
        walk(1, 20);
        settle();
        check("after_jump_cw", n_cw, 5);
        check("after_jump_position", position, 5);
        walk(1, 20);

        repeat (121) walk(1, 5);
        settle();
        check("pos_127", position, 127);
        walk(1, 5);
        settle();
        check("wrap_up", position, 8'h80);
        walk(-1, 5); walk(-1, 5);
        settle();
        check("wrap_down", position, 126);

        @(negedge CLK);
        k = (k + 3) % 4;
        {enc_a, enc_b} = seq[k];
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        clear = 1;
        @(posedge CLK);
        #2;
        check("clear_ccw_pulse", step_ccw, 1);
        check("clear_position", position, 0);
        check("clear_velocity", velocity, m_vel & 255);
        @(negedge CLK);
        clear = 0;
        walk(1, 6); walk(1, 6);
        repeat (3) @(posedge CLK);

        @(negedge CLK);
        reset = 1;
        #1;
        check("async_position", position, 0);
        check("async_velocity", velocity, 0);
        check("async_pulses", {step_cw, step_ccw, err}, 0);
        {enc_a, enc_b} = 2'b00; k = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        reset = 0;
        rel = cyc;
        repeat (200) walk(1, 4);
        while (cyc < rel + 1005) @(posedge CLK);
        @(negedge CLK);
        check("vel_saturated", velocity, 127);
        while (cyc < rel + 2005) @(posedge CLK);
        @(negedge CLK);
        check("vel_empty_window", velocity, 0);

        repeat (500) begin
            r = $urandom_range(0, 9);
            if (r < 6) k = (k + 1) % 4;
            else if (r < 8) k = (k + 3) % 4;
            else if (r == 8) k = (k + 2) % 4;
            else put(seq[(k + 1) % 4], $urandom_range(1, 3), 1'b0);
            put(seq[k], $urandom_range(1, 7), $urandom_range(0, 15) == 0);
        end
        put(seq[k], 12, 1'b0);

        @(negedge CLK);
        reset = 1;
        #1;
        check("final_reset_position", position, 0);
        check("final_reset_velocity", velocity, 0);
        check("final_reset_pulses", {step_cw, step_ccw, err}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
